pulse_burst_sequencer: RTL and testbench
========================================

PULSE_BURST_SEQUENCER -- requirements
Module: pulse_burst_sequencer

Interface
REQ-001 Parameters SHALL be: TIME_W=64 (time width); TMR_W=32 (interval timer width); NP_W=16 (pulse-count width); FREQ_W=48 (DDS word width); CMD_DEPTH=4 (command queue depth, power of 2, >=2).
REQ-002 CLK  in  1  single clock, 48 MHz.
REQ-003 RESET  in  1  asynchronous, active-high reset.
REQ-004 TIME  in  TIME_W  system time, +1 per CLK when synchronised.
REQ-005 TIME_VALID  in  1  system time synchronised to the second mark.
REQ-006 CMD_WR  in  1  one-cycle push strobe for CMD_DATA.
REQ-007 CMD_DATA  in  cmd_t  command: freq, delta_freq, delta_rate, t_start, n_pulse, type[1:0], Ti, Tp, Tblank1, Tblank2.
REQ-008 ABORT  in  1  one-cycle strobe: stop burst and flush queue.
REQ-009 ACK  in  1  DDS CDC acknowledge.
REQ-010 REQ  out  1  DDS parameter-transfer request.
REQ-011 DDS_freq / DDS_delta_freq / DDS_delta_rate  out  FREQ_W/FREQ_W/32  held DDS words.
REQ-012 DDS_start, En_Iz, En_Pr, En_ADC  out  1 each  DDS run, transmit gate, receive gate, ADC window.
REQ-013 CMD_LEVEL  out  $clog2(CMD_DEPTH)+1  queue occupancy; CMD_FULL  out  1.
REQ-014 BUSY  out  1  burst in progress; DONE, ERR_LATE, ERR_OVF  out  1 each  one-cycle pulses.

Function
REQ-015 States SHALL be IDLE, POP, WAIT_T, LOAD, BLANK1, TIZL, BLANK2, TPR, NEXT.
REQ-016 IDLE->POP when queue non-empty and TIME_VALID=1; POP reads head in one cycle.
REQ-017 In POP, TIME > t_start SHALL discard the command, pulse ERR_LATE, return to IDLE; otherwise go to WAIT_T.
REQ-018 WAIT_T->LOAD when TIME >= t_start; n_pulse=0 SHALL go directly to NEXT, pulse DONE, emit no gates.
REQ-019 LOAD loads the four timers and decrements the remaining pulse count; -> BLANK1.
REQ-020 Each interval value V SHALL last exactly V cycles; V=0 SHALL be treated as 1.
REQ-021 En_Iz=1 exactly during TIZL; En_Pr=1 exactly during TPR.
REQ-022 DDS_start SHALL rise on TIZL entry and clear on BLANK2 entry unless type[0]=1 and pulses remain.
REQ-023 REQ SHALL assert on LOAD entry for every pulse when type[0]=0, for the first pulse only when type[0]=1; DDS words SHALL update in the same cycle.
REQ-024 REQ SHALL stay high until ACK=1, then drop; a new REQ SHALL wait for ACK=0.
REQ-025 BLANK1 SHALL NOT exit while REQ=1; it extends until ACK is seen.
REQ-026 NEXT: pulses remain -> LOAD; else pulse DONE -> IDLE (back-to-back commands allowed).
REQ-027 En_ADC SHALL be En_Pr when type[1]=1, else En_Iz, delayed one CLK.
REQ-028 BUSY=1 in every state except IDLE.
REQ-029 CMD_WR while full SHALL drop data and pulse ERR_OVF; a write and a pop in the same cycle SHALL both take effect.
REQ-030 ABORT or TIME_VALID falling SHALL force IDLE next cycle and drop gates, DDS_start and REQ; ABORT also flushes the queue; TIME_VALID loss keeps it.
REQ-031 ABORT SHALL win over a simultaneous CMD_WR.

Reset
REQ-032 RESET SHALL clear the queue and all outputs to 0 (DDS words included) and set state to IDLE.

Configuration
REQ-033 With BURST_STATUS_EN defined, outputs PULSE_IDX (NP_W, 1-based current pulse) and LATE_CNT (16, saturating count of ERR_LATE) SHALL exist; without it both SHALL be absent.

Structure
REQ-034 Package pulse_seq_pkg SHALL hold cmd_t, the state enum and width defaults.
REQ-035 Sub-module pulse_cmd_fifo SHALL implement the command queue, including level and full flags.

Verification
REQ-036 t_start=TIME+100, n=2, Tb1=3, Ti=5, Tb2=2, Tp=4, type=0 -> two En_Iz windows of 5 cycles, En_Pr windows of 4, two REQ, DONE once.
REQ-037 type=01, n=3 -> one REQ, DDS_start high from first TIZL to last BLANK2.
REQ-038 t_start=TIME-1 at POP -> ERR_LATE, no gates, next queued command runs.
REQ-039 Five writes with DEPTH=4 while busy -> ERR_OVF on the fifth, CMD_LEVEL=4.
REQ-040 ACK delayed 10 cycles with Tb1=3 -> BLANK1 lasts until ACK, then TIZL.
REQ-041 ABORT mid-TIZL -> En_Iz low next cycle, CMD_LEVEL=0, BUSY=0.

Source files
------------

// File: rtl/pulse_burst_sequencer_pkg.sv
// Shared types for the pulse burst sequencer: command word, FSM states,
// default widths and the interval-to-counter helper.
package pulse_seq_pkg;

  localparam int P_TIME_W    = 64;
  localparam int P_TMR_W     = 32;
  localparam int P_NP_W      = 16;
  localparam int P_FREQ_W    = 48;
  localparam int P_RATE_W    = 32;
  localparam int P_CMD_DEPTH = 4;

  typedef struct packed {
    logic [P_FREQ_W-1:0] freq;
    logic [P_FREQ_W-1:0] delta_freq;
    logic [P_RATE_W-1:0] delta_rate;
    logic [P_TIME_W-1:0] t_start;
    logic [P_NP_W-1:0]   n_pulse;
    logic [1:0]          ctype;
    logic [P_TMR_W-1:0]  ti;
    logic [P_TMR_W-1:0]  tp;
    logic [P_TMR_W-1:0]  tblank1;
    logic [P_TMR_W-1:0]  tblank2;
  } cmd_t;

  typedef enum logic [3:0] {
    IDLE, POP, WAIT_T, LOAD, BLANK1, TIZL, BLANK2, TPR, NEXT
  } state_t;

  // A state that must last V cycles counts down from V-1; zero behaves as one.
  function automatic logic [P_TMR_W-1:0] interval_cnt(input logic [P_TMR_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

endpackage

// File: rtl/pulse_burst_sequencer_if.sv
// DDS parameter-transfer bundle: request/acknowledge handshake, held DDS
// words and the DDS run strobe.
interface pulse_burst_sequencer_if;
  import pulse_seq_pkg::*;

  logic                req;
  logic                ack;
  logic                dds_start;
  logic [P_FREQ_W-1:0] dds_freq;
  logic [P_FREQ_W-1:0] dds_delta_freq;
  logic [P_RATE_W-1:0] dds_delta_rate;

  modport master (
    output req, dds_start, dds_freq, dds_delta_freq, dds_delta_rate,
    input  ack
  );

  modport slave (
    input  req, dds_start, dds_freq, dds_delta_freq, dds_delta_rate,
    output ack
  );

endinterface

// File: rtl/pulse_cmd_fifo.sv
// Command queue for the burst sequencer: head is read combinationally,
// flush beats a simultaneous write, a write into a full queue is dropped.
module pulse_cmd_fifo
  import pulse_seq_pkg::*;
#(
  parameter  int DEPTH = P_CMD_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  cmd_t        din,
  input  logic        rd,
  input  logic        flush,
  output cmd_t        head,
  output logic [AW:0] level,
  output logic        full,
  output logic        empty,
  output logic        ovf
);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_rd;
  logic          do_wr;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign head  = mem[rptr];

  // A pop in the same cycle frees the slot, so a write to a full queue still lands.
  assign do_rd = rd && !empty && !flush;
  assign do_wr = wr && !flush && (!full || do_rd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      ovf   <= 1'b0;
    end else begin
      ovf <= wr && !flush && full && !do_rd;
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        level <= '0;
      end else begin
        if (do_wr) wptr <= wptr + 1'b1;
        if (do_rd) rptr <= rptr + 1'b1;
        case ({do_wr, do_rd})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= din;
  end

endmodule

// File: rtl/pulse_burst_sequencer.sv
// Time-triggered pulse burst sequencer driving DDS words and Tx/Rx/ADC gates.
// Define BURST_STATUS_EN to add the pulse_idx and late_cnt status outputs.
module pulse_burst_sequencer
  import pulse_seq_pkg::*;
#(
  parameter  int TIME_W    = P_TIME_W,
  parameter  int TMR_W     = P_TMR_W,
  parameter  int NP_W      = P_NP_W,
  parameter  int FREQ_W    = P_FREQ_W,
  parameter  int CMD_DEPTH = P_CMD_DEPTH,
  localparam int LVL_W     = $clog2(CMD_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [TIME_W-1:0]       sys_time,
  input  logic                    time_valid,
  input  logic                    cmd_wr,
  input  cmd_t                    cmd_data,
  input  logic                    abort,
  pulse_burst_sequencer_if.master dds,
  output logic                    en_iz,
  output logic                    en_pr,
  output logic                    en_adc,
  output logic [LVL_W-1:0]        cmd_level,
  output logic                    cmd_full,
  output logic                    busy,
  output logic                    done,
  output logic                    err_late,
  output logic                    err_ovf
`ifdef BURST_STATUS_EN
  ,
  output logic [NP_W-1:0]         pulse_idx,
  output logic [15:0]             late_cnt
`endif
);

  state_t           st;
  cmd_t             cur;
  cmd_t             head;
  logic             empty;
  logic             fifo_rd;
  logic             load_req;
  logic             req_pend;
  logic [TMR_W-1:0] cnt;
  logic [NP_W-1:0]  rem;

  assign fifo_rd  = (st == POP) && !abort && time_valid;
  // The first pulse always requests; chirp-continuation commands skip the rest.
  assign load_req = (st == WAIT_T) || !cur.ctype[0];

  pulse_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (cmd_wr),
    .din   (cmd_data),
    .rd    (fifo_rd),
    .flush (abort),
    .head  (head),
    .level (cmd_level),
    .full  (cmd_full),
    .empty (empty),
    .ovf   (err_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st                 <= IDLE;
      cnt                <= '0;
      rem                <= '0;
      req_pend           <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      err_late           <= 1'b0;
      en_iz              <= 1'b0;
      en_pr              <= 1'b0;
      en_adc             <= 1'b0;
      dds.req            <= 1'b0;
      dds.dds_start      <= 1'b0;
      dds.dds_freq       <= '0;
      dds.dds_delta_freq <= '0;
      dds.dds_delta_rate <= '0;
    end else begin
      done     <= 1'b0;
      err_late <= 1'b0;
      en_adc   <= (cur.ctype[1] & en_pr) | (~cur.ctype[1] & en_iz);
      if (dds.req && dds.ack) begin
        dds.req <= 1'b0;
      end else if (req_pend && !dds.ack) begin
        dds.req  <= 1'b1;
        req_pend <= 1'b0;
      end
      if (cnt != '0) cnt <= cnt - 1'b1;

      if (st != IDLE && (abort || !time_valid)) begin
        st            <= IDLE;
        busy          <= 1'b0;
        en_iz         <= 1'b0;
        en_pr         <= 1'b0;
        en_adc        <= 1'b0;
        dds.dds_start <= 1'b0;
        dds.req       <= 1'b0;
        req_pend      <= 1'b0;
      end else begin
        case (st)
          IDLE: begin
            if (!empty && time_valid && !abort) begin
              st   <= POP;
              busy <= 1'b1;
            end
          end
          POP: begin
            cur <= head;
            rem <= head.n_pulse;
            if (sys_time > head.t_start) begin
              err_late <= 1'b1;
              st       <= IDLE;
              busy     <= 1'b0;
            end else begin
              st <= WAIT_T;
            end
          end
          WAIT_T, NEXT: begin
            if (st == NEXT && rem == '0) begin
              done <= 1'b1;
              st   <= IDLE;
              busy <= 1'b0;
            end else if (st == WAIT_T && sys_time < cur.t_start) begin
              st <= WAIT_T;
            end else if (rem == '0) begin
              st <= NEXT;
            end else begin
              st <= LOAD;
              if (load_req) begin
                dds.dds_freq       <= cur.freq[FREQ_W-1:0];
                dds.dds_delta_freq <= cur.delta_freq[FREQ_W-1:0];
                dds.dds_delta_rate <= cur.delta_rate;
                // A previous ACK still high holds the new request back.
                if (dds.ack) req_pend <= 1'b1;
                else         dds.req  <= 1'b1;
              end
            end
          end
          LOAD: begin
            rem <= rem - 1'b1;
            cnt <= interval_cnt(cur.tblank1);
            st  <= BLANK1;
          end
          BLANK1: begin
            if (cnt == '0 && !dds.req && !req_pend) begin
              st            <= TIZL;
              cnt           <= interval_cnt(cur.ti);
              en_iz         <= 1'b1;
              dds.dds_start <= 1'b1;
            end
          end
          TIZL: begin
            if (cnt == '0) begin
              st    <= BLANK2;
              cnt   <= interval_cnt(cur.tblank2);
              en_iz <= 1'b0;
              if (!(cur.ctype[0] && rem != '0)) dds.dds_start <= 1'b0;
            end
          end
          BLANK2: begin
            if (cnt == '0) begin
              st    <= TPR;
              cnt   <= interval_cnt(cur.tp);
              en_pr <= 1'b1;
            end
          end
          TPR: begin
            if (cnt == '0) begin
              st    <= NEXT;
              en_pr <= 1'b0;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

`ifdef BURST_STATUS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_idx <= '0;
      late_cnt  <= '0;
    end else begin
      if (st == POP)       pulse_idx <= '0;
      else if (st == LOAD) pulse_idx <= pulse_idx + 1'b1;
      if (err_late && late_cnt != 16'hFFFF) late_cnt <= late_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pulse_burst_sequencer.sv
// Directed self-checking bench for pulse_burst_sequencer with a DDS ACK
// responder of programmable latency and a free-running system time.
module tb_pulse_burst_sequencer;
  import pulse_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] sys_time;
  logic        time_valid;
  logic        cmd_wr;
  cmd_t        cmd_data;
  logic        abort;
  logic        en_iz, en_pr, en_adc;
  logic [2:0]  cmd_level;
  logic        cmd_full, busy, done, err_late, err_ovf;
`ifdef BURST_STATUS_EN
  logic [15:0] pulse_idx;
  logic [15:0] late_cnt;
`endif

  pulse_burst_sequencer_if dds_if ();

  pulse_burst_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .sys_time   (sys_time),
    .time_valid (time_valid),
    .cmd_wr     (cmd_wr),
    .cmd_data   (cmd_data),
    .abort      (abort),
    .dds        (dds_if),
    .en_iz      (en_iz),
    .en_pr      (en_pr),
    .en_adc     (en_adc),
    .cmd_level  (cmd_level),
    .cmd_full   (cmd_full),
    .busy       (busy),
    .done       (done),
    .err_late   (err_late),
    .err_ovf    (err_ovf)
`ifdef BURST_STATUS_EN
    ,
    .pulse_idx  (pulse_idx),
    .late_cnt   (late_cnt)
`endif
  );

  always #5 clk = ~clk;

  // System time advances once per clock while synchronised.
  initial begin
    sys_time = 64'd1000;
    forever begin
      @(negedge clk);
      if (time_valid === 1'b1) sys_time = sys_time + 64'd1;
    end
  end

  // DDS side: raise ACK after ack_delay cycles of REQ, drop it once REQ falls.
  int ack_delay = 1;
  int ack_cnt;
  initial begin
    dds_if.ack = 1'b0;
    ack_cnt    = 0;
    forever begin
      @(negedge clk);
      if (dds_if.req === 1'b1) begin
        if (!dds_if.ack) begin
          ack_cnt = ack_cnt + 1;
          if (ack_cnt >= ack_delay) dds_if.ack = 1'b1;
        end
      end else begin
        dds_if.ack = 1'b0;
        ack_cnt    = 0;
      end
    end
  end

  int tests = 0;
  int fails = 0;
  int sidx  = 0;
  int iz_lens[$], pr_lens[$], adc_lens[$];
  int iz_run, pr_run, adc_run;
  int req_rises, done_cnt, late_m, ovf_m, ds_rises, ds_high;
  int first_req, first_iz;
  logic prev_req, prev_ds;

  function automatic string lens_str(input int q[$]);
    string s;
    s = "{";
    foreach (q[i]) s = {s, $sformatf(" %0d", q[i])};
    return {s, " }"};
  endfunction

  function automatic cmd_t mk(input logic [63:0] ts, input logic [15:0] n,
                              input logic [1:0] ty, input logic [31:0] tb1,
                              input logic [31:0] ti, input logic [31:0] tb2,
                              input logic [31:0] tp, input logic [47:0] f);
    cmd_t c;
    c.freq       = f;
    c.delta_freq = f + 48'd1;
    c.delta_rate = 32'h0000_1234;
    c.t_start    = ts;
    c.n_pulse    = n;
    c.ctype      = ty;
    c.ti         = ti;
    c.tp         = tp;
    c.tblank1    = tb1;
    c.tblank2    = tb2;
    return c;
  endfunction

  task automatic mon_clear();
    iz_lens.delete(); pr_lens.delete(); adc_lens.delete();
    iz_run = 0; pr_run = 0; adc_run = 0;
    req_rises = 0; done_cnt = 0; late_m = 0; ovf_m = 0; ds_rises = 0; ds_high = 0;
    first_req = -1; first_iz = -1;
    prev_req = dds_if.req; prev_ds = dds_if.dds_start;
  endtask

  task automatic tick();
    @(negedge clk);
    sidx = sidx + 1;
    if (en_iz) iz_run++; else if (iz_run > 0) begin iz_lens.push_back(iz_run); iz_run = 0; end
    if (en_pr) pr_run++; else if (pr_run > 0) begin pr_lens.push_back(pr_run); pr_run = 0; end
    if (en_adc) adc_run++; else if (adc_run > 0) begin adc_lens.push_back(adc_run); adc_run = 0; end
    if (en_iz && iz_run == 1 && first_iz < 0) first_iz = sidx;
    if (dds_if.req && !prev_req) begin
      req_rises++;
      if (first_req < 0) first_req = sidx;
    end
    if (dds_if.dds_start && !prev_ds) ds_rises++;
    if (dds_if.dds_start) ds_high++;
    if (done) done_cnt++;
    if (err_late) late_m++;
    if (err_ovf) ovf_m++;
    prev_req = dds_if.req;
    prev_ds  = dds_if.dds_start;
  endtask

  task automatic push(input cmd_t c);
    cmd_data = c;
    cmd_wr   = 1'b1;
    tick();
    cmd_wr   = 1'b0;
  endtask

  task automatic run_until_idle(input int max_cycles, input string name);
    int n;
    n = 0;
    repeat (3) tick();
    while (!(!busy && cmd_level == 3'd0 && iz_run == 0 && pr_run == 0 && adc_run == 0)
           && n < max_cycles) begin
      tick();
      n++;
    end
    tests++;
    if (n >= max_cycles) begin
      fails++;
      $display("FAIL %s timeout: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; time_valid = 1'b0; cmd_wr = 1'b0; abort = 1'b0; cmd_data = '0;
    repeat (3) tick();
    tests++;
    if (busy !== 1'b0 || cmd_level !== 3'd0) begin
      fails++; $display("FAIL reset_busy_level: busy=%b level=%0d, required 0/0", busy, cmd_level);
    end
    tests++;
    if ({en_iz, en_pr, en_adc, dds_if.req, dds_if.dds_start, done, err_late, err_ovf, cmd_full} !== 9'b0) begin
      fails++; $display("FAIL reset_flags: got %b, required all 0",
        {en_iz, en_pr, en_adc, dds_if.req, dds_if.dds_start, done, err_late, err_ovf, cmd_full});
    end
    tests++;
    if (dds_if.dds_freq !== 48'd0 || dds_if.dds_delta_freq !== 48'd0 || dds_if.dds_delta_rate !== 32'd0) begin
      fails++; $display("FAIL reset_dds_words: freq=%h dfreq=%h drate=%h, required 0",
        dds_if.dds_freq, dds_if.dds_delta_freq, dds_if.dds_delta_rate);
    end
    rst = 1'b0;
    time_valid = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_basic_burst();
    int s_push;
    mon_clear();
    push(mk(sys_time + 64'd100, 16'd2, 2'b00, 32'd3, 32'd5, 32'd2, 32'd4, 48'h0000_1234_5678));
    s_push = sidx;
    repeat (3) tick();
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_wait: busy=%b, required 1", busy); end
    run_until_idle(400, "basic");
    tests++;
    if (iz_lens.size() != 2 || iz_lens[0] != 5 || iz_lens[1] != 5) begin
      fails++; $display("FAIL basic_iz: got %s, required { 5 5 }", lens_str(iz_lens));
    end
    tests++;
    if (pr_lens.size() != 2 || pr_lens[0] != 4 || pr_lens[1] != 4) begin
      fails++; $display("FAIL basic_pr: got %s, required { 4 4 }", lens_str(pr_lens));
    end
    tests++;
    if (adc_lens.size() != 2 || adc_lens[0] != 5 || adc_lens[1] != 5) begin
      fails++; $display("FAIL basic_adc: got %s, required { 5 5 }", lens_str(adc_lens));
    end
    tests++;
    if (req_rises != 2 || done_cnt != 1 || ds_rises != 2) begin
      fails++; $display("FAIL basic_counts: req=%0d done=%0d ds=%0d, required 2/1/2", req_rises, done_cnt, ds_rises);
    end
    tests++;
    if (first_iz - first_req != 4) begin
      fails++; $display("FAIL basic_blank1: req->iz %0d cycles, required 4", first_iz - first_req);
    end
    tests++;
    if (first_req - s_push < 97 || first_req - s_push > 104) begin
      fails++; $display("FAIL basic_start_time: req after %0d cycles, required 97..104", first_req - s_push);
    end
    tests++;
    if (dds_if.dds_freq !== 48'h0000_1234_5678) begin
      fails++; $display("FAIL basic_dds_freq: got %h, required 000012345678", dds_if.dds_freq);
    end
  endtask

  task automatic test_chirp_type01();
    mon_clear();
    push(mk(sys_time + 64'd10, 16'd3, 2'b01, 32'd2, 32'd3, 32'd2, 32'd2, 48'h0000_00AB_CDEF));
    run_until_idle(400, "chirp");
    tests++;
    if (req_rises != 1 || ds_rises != 1 || done_cnt != 1) begin
      fails++; $display("FAIL chirp_counts: req=%0d ds=%0d done=%0d, required 1/1/1", req_rises, ds_rises, done_cnt);
    end
    tests++;
    if (ds_high != 25) begin
      fails++; $display("FAIL chirp_ds_high: got %0d cycles, required 25", ds_high);
    end
    tests++;
    if (iz_lens.size() != 3 || iz_lens[0] != 3 || iz_lens[2] != 3 || adc_lens.size() != 3) begin
      fails++; $display("FAIL chirp_gates: iz %s adc %s, required { 3 3 3 } each", lens_str(iz_lens), lens_str(adc_lens));
    end
    tests++;
    if (dds_if.dds_delta_freq !== 48'h0000_00AB_CDF0) begin
      fails++; $display("FAIL chirp_dds_dfreq: got %h, required 000000ABCDF0", dds_if.dds_delta_freq);
    end
  endtask

  task automatic test_late();
    mon_clear();
    push(mk(sys_time - 64'd1, 16'd2, 2'b00, 32'd1, 32'd7, 32'd1, 32'd1, 48'd1));
    push(mk(sys_time + 64'd20, 16'd1, 2'b00, 32'd1, 32'd2, 32'd1, 32'd1, 48'd2));
    run_until_idle(200, "late");
    tests++;
    if (late_m != 1 || done_cnt != 1 || req_rises != 1) begin
      fails++; $display("FAIL late_counts: late=%0d done=%0d req=%0d, required 1/1/1", late_m, done_cnt, req_rises);
    end
    tests++;
    if (iz_lens.size() != 1 || iz_lens[0] != 2) begin
      fails++; $display("FAIL late_gates: got %s, required { 2 }", lens_str(iz_lens));
    end
  endtask

  task automatic test_zero_values();
    mon_clear();
    push(mk(sys_time + 64'd5, 16'd0, 2'b00, 32'd3, 32'd3, 32'd3, 32'd3, 48'd3));
    push(mk(sys_time + 64'd30, 16'd1, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 48'd4));
    run_until_idle(200, "zero");
    tests++;
    if (done_cnt != 2 || req_rises != 1) begin
      fails++; $display("FAIL zero_counts: done=%0d req=%0d, required 2/1", done_cnt, req_rises);
    end
    tests++;
    if (iz_lens.size() != 1 || iz_lens[0] != 1 || pr_lens.size() != 1 || pr_lens[0] != 1) begin
      fails++; $display("FAIL zero_len: iz %s pr %s, required { 1 } each", lens_str(iz_lens), lens_str(pr_lens));
    end
    tests++;
    if (first_iz - first_req != 2) begin
      fails++; $display("FAIL zero_blank1: req->iz %0d cycles, required 2", first_iz - first_req);
    end
  endtask

  task automatic test_overflow();
    int ovf_before;
    mon_clear();
    push(mk(sys_time + 64'd300, 16'd1, 2'b00, 32'd1, 32'd1, 32'd1, 32'd1, 48'd5));
    repeat (4) tick();
    for (int i = 0; i < 4; i++) push(mk(sys_time + 64'd900, 16'd1, 2'b00, 32'd1, 32'd1, 32'd1, 32'd1, 48'd6));
    ovf_before = ovf_m;
    push(mk(sys_time + 64'd900, 16'd1, 2'b00, 32'd1, 32'd1, 32'd1, 32'd1, 48'd7));
    tests++;
    if (ovf_before != 0 || ovf_m != 1) begin
      fails++; $display("FAIL ovf_pulse: before fifth=%0d after=%0d, required 0/1", ovf_before, ovf_m);
    end
    tests++;
    if (cmd_level !== 3'd4 || cmd_full !== 1'b1) begin
      fails++; $display("FAIL ovf_level: level=%0d full=%b, required 4/1", cmd_level, cmd_full);
    end
    cmd_data = mk(sys_time, 16'd1, 2'b00, 32'd1, 32'd1, 32'd1, 32'd1, 48'd8);
    cmd_wr = 1'b1; abort = 1'b1;
    tick();
    cmd_wr = 1'b0; abort = 1'b0;
    tick();
    tests++;
    if (cmd_level !== 3'd0 || busy !== 1'b0) begin
      fails++; $display("FAIL abort_wins_write: level=%0d busy=%b, required 0/0", cmd_level, busy);
    end
  endtask

  task automatic test_abort();
    int guard;
    mon_clear();
    push(mk(sys_time + 64'd5, 16'd2, 2'b00, 32'd2, 32'd20, 32'd2, 32'd2, 48'd9));
    push(mk(sys_time + 64'd60, 16'd1, 2'b00, 32'd2, 32'd2, 32'd2, 32'd2, 48'd10));
    guard = 0;
    while (!en_iz && guard < 100) begin tick(); guard++; end
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++;
    if (en_iz !== 1'b0 || cmd_level !== 3'd0 || busy !== 1'b0) begin
      fails++; $display("FAIL abort_state: en_iz=%b level=%0d busy=%b, required 0/0/0", en_iz, cmd_level, busy);
    end
    tests++;
    if (dds_if.dds_start !== 1'b0 || dds_if.req !== 1'b0) begin
      fails++; $display("FAIL abort_dds: start=%b req=%b, required 0/0", dds_if.dds_start, dds_if.req);
    end
    repeat (80) tick();
    tests++;
    if (iz_lens.size() != 1 || done_cnt != 0) begin
      fails++; $display("FAIL abort_flush: iz windows %0d done %0d, required 1/0", iz_lens.size(), done_cnt);
    end
  endtask

  task automatic test_ack_delay();
    mon_clear();
    ack_delay = 10;
    push(mk(sys_time + 64'd10, 16'd1, 2'b10, 32'd3, 32'd4, 32'd1, 32'd3, 48'd11));
    run_until_idle(200, "ack_delay");
    ack_delay = 1;
    tests++;
    if (first_iz - first_req != 11) begin
      fails++; $display("FAIL ack_blank1: req->iz %0d cycles, required 11", first_iz - first_req);
    end
    tests++;
    if (iz_lens.size() != 1 || iz_lens[0] != 4 || adc_lens.size() != 1 || adc_lens[0] != 3) begin
      fails++; $display("FAIL ack_gates: iz %s adc %s, required { 4 } / { 3 }", lens_str(iz_lens), lens_str(adc_lens));
    end
  endtask

  task automatic test_time_loss();
    int guard;
    mon_clear();
    push(mk(sys_time + 64'd5, 16'd1, 2'b00, 32'd2, 32'd30, 32'd2, 32'd2, 48'd12));
    push(mk(sys_time + 64'd200, 16'd1, 2'b00, 32'd2, 32'd2, 32'd2, 32'd2, 48'd13));
    guard = 0;
    while (!en_iz && guard < 100) begin tick(); guard++; end
    repeat (2) tick();
    time_valid = 1'b0;
    tick();
    tests++;
    if (en_iz !== 1'b0 || busy !== 1'b0 || cmd_level !== 3'd1) begin
      fails++; $display("FAIL tloss_state: en_iz=%b busy=%b level=%0d, required 0/0/1", en_iz, busy, cmd_level);
    end
    repeat (5) tick();
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL tloss_hold: busy=%b, required 0", busy); end
    time_valid = 1'b1;
    run_until_idle(400, "tloss");
    tests++;
    if (iz_lens.size() != 2 || iz_lens[1] != 2 || done_cnt != 1 || late_m != 0) begin
      fails++; $display("FAIL tloss_resume: iz %s done=%0d late=%0d, required 2 windows ending 2, 1, 0",
        lens_str(iz_lens), done_cnt, late_m);
    end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_chirp_type01();
    test_late();
    test_zero_values();
    test_overflow();
    test_abort();
    test_ack_delay();
    test_time_loss();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
